// File: rtl/div_8x4_seq_if.sv
// ---------------------------------------------------------------------------
// div_8x4_seq_if
//   Start/busy/done handshake bundle for the sequential 8x4 divider.
//
//   start        master -> slave  request, taken on an edge where busy=0
//   dividend     master -> slave  DIVIDEND_W-bit operand
//   divisor      master -> slave  DIVISOR_W-bit operand
//   busy         slave  -> master division in progress
//   done         slave  -> master one-cycle completion pulse
//   quotient     slave  -> master DIVIDEND_W-bit result, held
//   remainder    slave  -> master DIVISOR_W-bit result, held
//   div_by_zero  slave  -> master divisor was zero, held with results
// ---------------------------------------------------------------------------
interface div_8x4_seq_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_8x4_seq.sv
// ---------------------------------------------------------------------------
// div_8x4_seq
//   Sequential radix-2 restoring divider, one quotient bit per clock.
//   Unsigned: done appears DIVIDEND_W+1 cycles after the accepting edge
//   (counting that edge's cycle as 1). Divisor 0 skips iteration and
//   reports quotient all-ones, remainder 0, div_by_zero=1.
//
//   Optional feature macro: DIV_SIGNED_EN
//     defined   -> two's complement operands; iteration runs on magnitudes
//                  and an extra FIX cycle restores the signs.
//     undefined -> unsigned only, no FIX state.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    div_8x4_seq_if.slave handshake and result bundle
// ---------------------------------------------------------------------------
module div_8x4_seq #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input logic           clk,
  input logic           rst_n,
  div_8x4_seq_if.slave  bus
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
`ifdef DIV_SIGNED_EN
    S_FIX  = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DIVIDEND_W-1:0] dvd_sh;    // dividend bits out at MSB, quotient bits in at LSB
  logic [DIVISOR_W-1:0]  dvs_r;
  logic [DIVISOR_W:0]    part;      // partial remainder
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] quot_r;
  logic [DIVISOR_W-1:0]  rem_r;
  logic                  dbz_r;
`ifdef DIV_SIGNED_EN
  logic                  q_neg;
  logic                  r_neg;
`endif

  logic                  accept;
  logic                  last;
  logic [DIVISOR_W+1:0]  wide;
  logic [DIVISOR_W+1:0]  p_diff;
  logic [DIVISOR_W:0]    p_step;
  logic [DIVIDEND_W-1:0] q_step;

  assign accept = bus.start && (state == S_IDLE || state == S_DONE);
  assign last   = (cnt == CNT_W'(DIVIDEND_W - 1));

  // ---------------- state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // ---------------- next-state logic ----------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_next = (bus.divisor == '0) ? S_DONE : S_CALC;
        else        state_next = S_IDLE;
      end
      S_CALC: begin
`ifdef DIV_SIGNED_EN
        if (last) state_next = S_FIX;
`else
        if (last) state_next = S_DONE;
`endif
      end
`ifdef DIV_SIGNED_EN
      S_FIX:   state_next = S_DONE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- output decode (from registered state only) ----------------
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      S_CALC:  bus.busy = 1'b1;
`ifdef DIV_SIGNED_EN
      S_FIX:   bus.busy = 1'b1;
`endif
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

  // ---------------- one restoring step ----------------
  // The shifted partial remainder is widened by one bit so the MSB of the
  // trial difference is its sign.
  always_comb begin
    wide   = {part, dvd_sh[DIVIDEND_W-1]};
    p_diff = wide - {2'b00, dvs_r};
    if (p_diff[DIVISOR_W+1]) begin
      p_step = wide[DIVISOR_W:0];
      q_step = {dvd_sh[DIVIDEND_W-2:0], 1'b0};
    end else begin
      p_step = p_diff[DIVISOR_W:0];
      q_step = {dvd_sh[DIVIDEND_W-2:0], 1'b1};
    end
  end

  // ---------------- datapath ----------------
  // NOTE: the datapath is a handful of flops, not a memory, so every one is
  // reset; an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh <= '0;
      dvs_r  <= '0;
      part   <= '0;
      cnt    <= '0;
      quot_r <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
`endif
    end else if (accept) begin
      part <= '0;
      cnt  <= '0;
`ifdef DIV_SIGNED_EN
      // Magnitudes stay unsigned, so the most negative values still fit.
      dvd_sh <= bus.dividend[DIVIDEND_W-1] ? -bus.dividend : bus.dividend;
      dvs_r  <= bus.divisor[DIVISOR_W-1]   ? -bus.divisor  : bus.divisor;
      q_neg  <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
      r_neg  <= bus.dividend[DIVIDEND_W-1];
`else
      dvd_sh <= bus.dividend;
      dvs_r  <= bus.divisor;
`endif
      if (bus.divisor == '0) begin
        quot_r <= '1;
        rem_r  <= '0;
        dbz_r  <= 1'b1;
      end else begin
        quot_r <= '0;
        rem_r  <= '0;
        dbz_r  <= 1'b0;
      end
    end else if (state == S_CALC) begin
      dvd_sh <= q_step;
      part   <= p_step;
      cnt    <= cnt + 1'b1;
`ifndef DIV_SIGNED_EN
      if (last) begin
        quot_r <= q_step;
        rem_r  <= p_step[DIVISOR_W-1:0];
      end
`endif
    end
`ifdef DIV_SIGNED_EN
    else if (state == S_FIX) begin
      quot_r <= q_neg ? -dvd_sh : dvd_sh;
      rem_r  <= r_neg ? -part[DIVISOR_W-1:0] : part[DIVISOR_W-1:0];
    end
`endif
  end

endmodule

// File: tb/tb_div_8x4_seq.sv
// ---------------------------------------------------------------------------
// tb_div_8x4_seq
//   Scoreboard bench for div_8x4_seq: every accepted start pushes the
//   expected result and completion cycle; a monitor pops on each done pulse.
// ---------------------------------------------------------------------------
module tb_div_8x4_seq;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         done_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  div_8x4_seq_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();

  div_8x4_seq #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, C-style truncation in signed mode.
  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    int   sa, sd, qi, ri;
    if (b == 4'h0) begin
      e.q = 8'hFF; e.r = 4'h0; e.dbz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sd = int'($signed(b));
`else
      sa = int'(a);
      sd = int'(b);
`endif
      qi = sa / sd;
      ri = sa % sd;
      e.q = qi[7:0]; e.r = ri[3:0]; e.dbz = 1'b0;
    end
    e.done_cyc = 0;
    return e;
  endfunction

  // Drive a start for one cycle from a negedge; t is the accepting edge index.
  task automatic issue(input logic [7:0] a, input logic [3:0] b,
                       input bit expect_accept, output int t);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    t = cyc + 1;
    if (expect_accept) begin
      e = model(a, b);
      e.done_cyc = t + ((b == 4'h0) ? 0 : LAT);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got a done pulse, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient",    32'(bus.quotient),    32'(e.q));
        check("remainder",   32'(bus.remainder),   32'(e.r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
        check("done_cycle",  32'(cyc),             32'(e.done_cyc));
        check("busy_at_done", 32'(bus.busy),       32'd0);
      end
    end
  end

  initial begin
    int t, t2, tx, lat, gap;
    logic [7:0] a;
    logic [3:0] b;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (3) @(negedge clk);
    check("rst_busy",      32'(bus.busy),        32'd0);
    check("rst_done",      32'(bus.done),        32'd0);
    check("rst_quotient",  32'(bus.quotient),    32'd0);
    check("rst_remainder", 32'(bus.remainder),   32'd0);
    check("rst_dbz",       32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 200/7
    issue(8'd200, 4'd7, 1'b1, t);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    wait_to(t + LAT - 1);
    check("no_early_done", 32'(bus.done), 32'd0);
    wait_to(t + LAT + 1);

    // Back-to-back: second start in the done cycle of the first.
    issue(8'd255, 4'd15, 1'b1, t);
    wait_to(t + LAT);
    issue(8'd5, 4'd9, 1'b1, t2);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    wait_to(t2 + LAT + 1);

    // Divide by zero, then a normal division clears the flag.
    issue(8'h5A, 4'h0, 1'b1, t);
    @(negedge clk);
    issue(8'h5A, 4'h3, 1'b1, t);
    check("dbz_cleared_on_accept",  32'(bus.div_by_zero), 32'd0);
    check("quot_cleared_on_accept", 32'(bus.quotient),    32'd0);
    wait_to(t + LAT + 1);

    // Start while busy is ignored.
    issue(8'd100, 4'd3, 1'b1, t);
    wait_to(t + 2);
    issue(8'h10, 4'h3, 1'b0, tx);
    wait_to(t + LAT + 3);

    // Reset mid-operation.
    issue(8'd200, 4'd7, 1'b1, t);
    wait_to(t + 3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",     32'(bus.busy),        32'd0);
    check("midrst_done",     32'(bus.done),        32'd0);
    check("midrst_quotient", 32'(bus.quotient),    32'd0);
    check("midrst_rem",      32'(bus.remainder),   32'd0);
    check("midrst_dbz",      32'(bus.div_by_zero), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd100, 4'd10, 1'b1, t);
    wait_to(t + LAT + 1);

`ifdef DIV_SIGNED_EN
    issue(8'h9C, 4'h7, 1'b1, t);
    wait_to(t + LAT + 1);
    issue(8'h80, 4'hF, 1'b1, t);
    wait_to(t + LAT + 1);
    issue(8'h7F, 4'h8, 1'b1, t);
    wait_to(t + LAT + 1);
`endif

    // Random traffic with gaps, back-to-back starts and ignored starts.
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      issue(a, b, 1'b1, t);
      lat = (b == 4'h0) ? 0 : LAT;
      if (lat != 0 && $urandom_range(0, 3) == 0)
        issue(8'($urandom), 4'($urandom_range(1, 15)), 1'b0, tx);
      gap = $urandom_range(0, 3);
      wait_to(t + lat + gap);
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
